// File: rtl/pipe_stage_pkg.sv
// Shared defines for the pipeline stage slice.
// Holds the reset polarity, the zero word and the occupancy state
// encodings used by pipe_stage and its counter.
package pipe_stage_pkg;

    localparam logic        RstEnable = 1'b0;
    localparam logic [31:0] ZeroWord  = 32'h0000_0000;

    // Occupancy encodings; kept as plain constants so legacy stage
    // registers can compare against them directly.
    localparam logic [1:0]  PS_EMPTY  = 2'd0;
    localparam logic [1:0]  PS_FULL   = 2'd1;
    localparam logic [1:0]  PS_SKIDF  = 2'd2;

endpackage

// File: rtl/pipe_stage_sat_counter.sv
// Saturating up-counter with synchronous clear.
// Ports:
//   clk  - rising-edge clock
//   rst  - asynchronous active-low reset, clears q
//   inc  - count up by one this cycle (held at all-ones once reached)
//   clr  - zero q; wins over inc
//   q    - current count
module sat_counter
    import pipe_stage_pkg::*;
#(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] q
);

    always_ff @(posedge clk or negedge rst) begin
        if (rst == RstEnable) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (inc && (q != {W{1'b1}})) begin
            q <= q + 1'b1;
        end
    end

endmodule

// File: rtl/pipe_stage.sv
// Valid/ready pipeline stage register with optional skid entry.
// Replaces the hand-written id_ex-style stage registers: the per-stage
// bundle (op, operands, write-back register, address) is packed into
// in_data and recovered from out_data.
//
// state    | meaning
// ---------+-----------------------------------------------
// PS_EMPTY | no entry held, out_data = NOP_VALUE
// PS_FULL  | main entry held and presented downstream
// PS_SKIDF | main + skid entries held (SKID=1 only)
//
// Ports:
//   clk, rst             - clock, asynchronous active-low reset
//   in_valid/in_ready    - upstream handshake, in_data payload
//   out_valid/out_ready  - downstream handshake, out_data payload
//   flush                - drop all held and incoming payloads
//   cnt_clr              - zero stall_cnt
//   stall_cnt            - saturating count of back-pressured cycles
module pipe_stage
    import pipe_stage_pkg::*;
#(
    parameter int                DATA_W    = 32,
    parameter int                SKID      = 1,
    parameter logic [DATA_W-1:0] NOP_VALUE = '0,
    parameter int                CNT_W     = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    input  logic              flush,
    input  logic              cnt_clr,
    output logic [CNT_W-1:0]  stall_cnt
);

    logic [1:0]        state_q;
    logic [1:0]        state_d;
    logic [DATA_W-1:0] main_q;
    logic [DATA_W-1:0] main_d;
    logic [DATA_W-1:0] skid_q;
    logic [DATA_W-1:0] skid_d;
    logic              accept;
    logic              issue;
    logic              stall_inc;

    assign out_valid = (state_q != PS_EMPTY);
    assign out_data  = main_q;
    assign accept    = in_valid && in_ready;
    assign issue     = out_valid && out_ready;
    assign stall_inc = out_valid && !out_ready;

    // main_q doubles as the output register, so every path into EMPTY
    // reloads it with the bubble value.
    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (flush) begin
            state_d = PS_EMPTY;
            main_d  = NOP_VALUE;
            skid_d  = NOP_VALUE;
        end else begin
            case (state_q)
                PS_EMPTY: begin
                    if (accept) begin
                        state_d = PS_FULL;
                        main_d  = in_data;
                    end
                end
                PS_FULL: begin
                    if (accept && issue) begin
                        main_d = in_data;
                    end else if (issue) begin
                        state_d = PS_EMPTY;
                        main_d  = NOP_VALUE;
                    end else if (accept && (SKID != 0)) begin
                        state_d = PS_SKIDF;
                        skid_d  = in_data;
                    end
                end
                PS_SKIDF: begin
                    if (issue) begin
                        state_d = PS_FULL;
                        main_d  = skid_q;
                        skid_d  = NOP_VALUE;
                    end
                end
                default: begin
                    state_d = PS_EMPTY;
                    main_d  = NOP_VALUE;
                    skid_d  = NOP_VALUE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (rst == RstEnable) begin
            state_q <= PS_EMPTY;
            main_q  <= NOP_VALUE;
            skid_q  <= NOP_VALUE;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
        end
    end

    generate
        if (SKID != 0) begin : g_skid_ready
            logic rdy_q;

            // rdy_q rests at 1 through reset and is masked by rst, so
            // ready reads 0 while held in reset yet is already 1 on the
            // first edge after release. out_ready never reaches it
            // combinationally.
            always_ff @(posedge clk or negedge rst) begin
                if (rst == RstEnable) begin
                    rdy_q <= 1'b1;
                end else begin
                    rdy_q <= (state_d != PS_SKIDF);
                end
            end

            assign in_ready = rdy_q && (rst != RstEnable);
        end else begin : g_comb_ready
            assign in_ready = (state_q == PS_EMPTY) || out_ready;
        end
    endgenerate

    sat_counter #(
        .W (CNT_W)
    ) u_stall_cnt (
        .clk (clk),
        .rst (rst),
        .inc (stall_inc),
        .clr (cnt_clr),
        .q   (stall_cnt)
    );

endmodule
